ikbd_link: RTL and testbench

IKBD_LINK -- requirements
Module: ikbd_link

---
 rtl/ikbd_link.sv | 201 ++++++++++++++++++++
 tb/tb_ikbd_link.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikbd_link.sv
// IKBD serial link: 8N1 transmitter and receiver, each buffered by a small FIFO.
// state | meaning: IDLE line idle | START start bit | DATA 8 bits LSB first | STOP stop bit
module ikbd_link #(
  parameter int TICK_DIV       = 64,
  parameter int FIFO_ADDR_BITS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_strobe,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  output logic       serial_out,
  input  logic       serial_in,
  output logic       rx_available,
  output logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  input  logic       err_clear
);
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW    = FIFO_ADDR_BITS;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          tx_s1, tx_s2, rx_s1, rx_s2, sin_s1, sin_s2;
  logic          tx_evt, rx_evt;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      tx_s1 <= 1'b0; tx_s2 <= 1'b0;
      rx_s1 <= 1'b0; rx_s2 <= 1'b0;
      sin_s1 <= 1'b0; sin_s2 <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      tx_s1 <= tx_strobe; tx_s2 <= tx_s1;
      rx_s1 <= rx_strobe; rx_s2 <= rx_s1;
      sin_s1 <= serial_in; sin_s2 <= sin_s1;
    end
  end

  assign tx_evt = tx_s1 & ~tx_s2;
  assign rx_evt = rx_s1 & ~rx_s2;

  // ---------------- transmit path ----------------
  logic [7:0]  tx_mem [DEPTH];
  logic [AW:0] tx_wptr, tx_rptr;
  logic        tx_empty, tx_push, tx_load;
  logic [1:0]  tx_state;
  logic [3:0]  tx_tcnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
  assign tx_push  = tx_evt & ~tx_full;
  // A new byte is taken either from idle or straight off the end of a stop bit.
  assign tx_load  = tick & ~tx_empty &
                    ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tcnt == 4'd0));

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_state <= S_IDLE;
      tx_tcnt  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_load) begin
        tx_rptr  <= tx_rptr + 1'b1;
        tx_shift <= tx_mem[tx_rptr[AW-1:0]];
        tx_state <= S_START;
        tx_tcnt  <= 4'd15;
      end else if (tick) begin
        case (tx_state)
          S_START: begin
            tx_tcnt <= tx_tcnt - 4'd1;
            if (tx_tcnt == 4'd0) begin
              tx_state <= S_DATA;
              tx_bit   <= 3'd0;
            end
          end
          S_DATA: begin
            tx_tcnt <= tx_tcnt - 4'd1;
            if (tx_tcnt == 4'd0) begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              if (tx_bit == 3'd7) tx_state <= S_STOP;
              else tx_bit <= tx_bit + 3'd1;
            end
          end
          S_STOP: begin
            tx_tcnt <= tx_tcnt - 4'd1;
            if (tx_tcnt == 4'd0) tx_state <= S_IDLE;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  assign serial_out = (tx_state == S_START) ? 1'b0 :
                      (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;

  // ---------------- receive path ----------------
  logic [7:0]  rx_mem [DEPTH];
  logic [AW:0] rx_wptr, rx_rptr;
  logic        rx_empty, rx_full, rx_push, rx_pop, rx_stop_smp;
  logic [3:0]  rx_filt_sr, rx_filt_nxt;
  logic        rx_filt;
  logic [1:0]  rx_state;
  logic [3:0]  rx_tcnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign rx_empty     = (rx_wptr == rx_rptr);
  assign rx_full      = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);
  assign rx_filt_nxt  = {rx_filt_sr[2:0], sin_s2};
  assign rx_stop_smp  = tick && (rx_state == S_STOP) && (rx_tcnt == 4'd0);
  assign rx_push      = rx_stop_smp & rx_filt & ~rx_full;
  assign rx_pop       = rx_evt & ~rx_empty;
  assign rx_available = ~rx_empty;
  assign rx_data      = rx_mem[rx_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr      <= '0;
      rx_rptr      <= '0;
      rx_filt_sr   <= 4'b1111;
      rx_filt      <= 1'b1;
      rx_state     <= S_IDLE;
      rx_tcnt      <= 4'd0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'd0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (err_clear) begin
        rx_frame_err <= 1'b0;
        rx_overrun   <= 1'b0;
      end else begin
        if (rx_stop_smp && !rx_filt)           rx_frame_err <= 1'b1;
        if (rx_stop_smp && rx_filt && rx_full) rx_overrun   <= 1'b1;
      end
      if (tick) begin
        rx_filt_sr <= rx_filt_nxt;
        if (rx_filt_nxt == 4'b0000)      rx_filt <= 1'b0;
        else if (rx_filt_nxt == 4'b1111) rx_filt <= 1'b1;
        case (rx_state)
          S_IDLE: begin
            if (!rx_filt) begin
              rx_state <= S_START;
              rx_tcnt  <= 4'd7;
            end
          end
          S_START: begin
            rx_tcnt <= rx_tcnt - 4'd1;
            if (rx_tcnt == 4'd0) begin
              rx_state <= rx_filt ? S_IDLE : S_DATA;
              rx_bit   <= 3'd0;
            end
          end
          S_DATA: begin
            rx_tcnt <= rx_tcnt - 4'd1;
            if (rx_tcnt == 4'd0) begin
              rx_shift <= {rx_filt, rx_shift[7:1]};
              if (rx_bit == 3'd7) rx_state <= S_STOP;
              else rx_bit <= rx_bit + 3'd1;
            end
          end
          S_STOP: begin
            rx_tcnt <= rx_tcnt - 4'd1;
            if (rx_tcnt == 4'd0) rx_state <= S_IDLE;
          end
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ikbd_link.sv
// Self-checking bench for ikbd_link: line-level decoder and queue models for both directions.
module tb_ikbd_link;
  localparam int TICK_DIV = 4;
  localparam int BIT      = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset_n, tx_strobe, rx_strobe, err_clear, rx_drv, loopback;
  logic [7:0] tx_data;
  logic       tx_full, serial_out, serial_in, rx_available, rx_frame_err, rx_overrun;
  logic [7:0] rx_data;

  assign serial_in = loopback ? serial_out : rx_drv;

  ikbd_link #(.TICK_DIV(TICK_DIV), .FIFO_ADDR_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .tx_strobe(tx_strobe), .tx_data(tx_data),
    .tx_full(tx_full), .serial_out(serial_out), .serial_in(serial_in),
    .rx_available(rx_available), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Line decoder: every frame seen on serial_out, sampled mid-bit.
  typedef struct { logic [7:0] data; logic ok; int start_cyc; int low_len; } txf_t;
  txf_t tx_seen[$];
  logic [7:0] tx_exp[$];

  initial begin : monitor
    int   t, st, low;
    logic busy, ok, lowdone;
    logic [7:0] d;
    busy = 1'b0; t = 0; st = 0; low = 0; ok = 1'b0; lowdone = 1'b0; d = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) busy = 1'b0;
      else if (!busy) begin
        if (serial_out === 1'b0) begin
          busy = 1'b1; t = 0; st = cyc; ok = 1'b1; low = 1; lowdone = 1'b0;
        end
      end else begin
        t++;
        if (!lowdone) begin
          if (serial_out === 1'b0) low++;
          else lowdone = 1'b1;
        end
        if (t == BIT / 2) ok &= (serial_out === 1'b0);
        for (int k = 0; k < 8; k++)
          if (t == BIT / 2 + (k + 1) * BIT) d[k] = serial_out;
        if (t == BIT / 2 + 9 * BIT) begin
          ok &= (serial_out === 1'b1);
          tx_seen.push_back('{d, ok, st, low});
          busy = 1'b0;
        end
      end
    end
  end

  // Receive-side reference: FIFO of 16 plus the two sticky flags.
  logic [7:0] rx_exp[$];
  logic       exp_ferr, exp_ovr;

  task automatic rx_model(input logic [7:0] b, input logic stop);
    if (!stop) exp_ferr = 1'b1;
    else if (rx_exp.size() >= 16) exp_ovr = 1'b1;
    else rx_exp.push_back(b);
  endtask

  task automatic push_tx(input logic [7:0] b, input bit model);
    tx_data = b; tx_strobe = 1'b1;
    wait_clk(3);
    tx_strobe = 1'b0;
    wait_clk(3);
    if (model) tx_exp.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0; wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; wait_clk(BIT); end
    rx_drv = stop; wait_clk(BIT);
    rx_drv = 1'b1;
  endtask

  task automatic pop_rx(input string name);
    logic [7:0] e;
    chk({name, " avail"}, rx_available, 1);
    e = rx_exp.pop_front();
    chk(name, rx_data, e);
    rx_strobe = 1'b1; wait_clk(3);
    rx_strobe = 1'b0; wait_clk(3);
  endtask

  task automatic clear_err();
    err_clear = 1'b1; wait_clk(2);
    err_clear = 1'b0; wait_clk(1);
    exp_ferr = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic wait_tx_frames(input int n, input string name);
    int k = 0;
    while (tx_seen.size() < n && k < (n + 2) * 12 * BIT) begin @(negedge clk); k++; end
    chk({name, " frames seen"}, tx_seen.size() >= n, 1);
  endtask

  task automatic check_tx(input string name);
    txf_t f;
    logic [7:0] e;
    wait_tx_frames(tx_exp.size(), name);
    while (tx_exp.size() > 0) begin
      e = tx_exp.pop_front();
      if (tx_seen.size() > 0) begin
        f = tx_seen.pop_front();
        chk({name, " byte"}, f.data, e);
        chk({name, " framing"}, f.ok, 1);
      end
    end
    chk({name, " extra frames"}, tx_seen.size(), 0);
  endtask

  typedef struct packed { logic [7:0] data; logic stop; logic avail; logic ferr; } rx_vec_t;
  rx_vec_t    rx_tab[6];
  logic [7:0] b, r;
  logic       st;
  int         k;

  initial begin : watchdog
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1);
  end

  initial begin
    rx_tab[0] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    rx_tab[1] = '{8'h55, 1'b0, 1'b0, 1'b1};
    rx_tab[2] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    rx_tab[3] = '{8'h00, 1'b1, 1'b1, 1'b0};
    rx_tab[4] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    rx_tab[5] = '{8'h81, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0; tx_strobe = 1'b0; rx_strobe = 1'b0; err_clear = 1'b0;
    rx_drv = 1'b1; loopback = 1'b0; tx_data = 8'h00;
    exp_ferr = 1'b0; exp_ovr = 1'b0;
    wait_clk(5);
    chk("reset serial_out", serial_out, 1);
    chk("reset tx_full", tx_full, 0);
    chk("reset rx_available", rx_available, 0);
    chk("reset rx_frame_err", rx_frame_err, 0);
    chk("reset rx_overrun", rx_overrun, 0);
    reset_n = 1'b1;
    wait_clk(2 * BIT);
    chk("idle line high", serial_out, 1);

    // single byte 0xA5 waveform
    push_tx(8'hA5, 1);
    wait_tx_frames(1, "a5");
    if (tx_seen.size() > 0) chk("a5 start bit length", tx_seen[0].low_len, BIT);
    check_tx("a5");
    wait_clk(BIT);
    chk("a5 line high after", serial_out, 1);

    // three bytes back to back: starts exactly 10 bit times apart
    push_tx(8'h3C, 1); push_tx(8'hC3, 1); push_tx(8'h81, 1);
    wait_tx_frames(3, "b2b");
    if (tx_seen.size() >= 3) begin
      chk("b2b gap 0-1", tx_seen[1].start_cyc - tx_seen[0].start_cyc, 10 * BIT);
      chk("b2b gap 1-2", tx_seen[2].start_cyc - tx_seen[1].start_cyc, 10 * BIT);
    end
    check_tx("b2b");

    // fill tx FIFO while the line is busy with one frame
    push_tx(8'h11, 1);
    k = 0;
    while (serial_out !== 1'b0 && k < 4 * BIT) begin @(negedge clk); k++; end
    chk("full: first frame started", serial_out, 0);
    for (int i = 0; i < 16; i++) begin
      push_tx(8'h20 + 8'(i), 1);
      if (i == 14) chk("tx_full after 15", tx_full, 0);
      if (i == 15) chk("tx_full after 16", tx_full, 1);
    end
    push_tx(8'hEE, 0);
    chk("tx_full after 17", tx_full, 1);
    check_tx("full");
    chk("tx_full drained", tx_full, 0);

    // table-driven receive frames
    for (int i = 0; i < 6; i++) begin
      send_frame(rx_tab[i].data, rx_tab[i].stop);
      rx_model(rx_tab[i].data, rx_tab[i].stop);
      wait_clk(2 * BIT);
      chk("tab avail", rx_available, rx_tab[i].avail);
      chk("tab frame_err", rx_frame_err, rx_tab[i].ferr);
      if (rx_tab[i].avail) begin
        chk("tab data", rx_data, rx_tab[i].data);
        void'(rx_exp.pop_front());
        rx_strobe = 1'b1; wait_clk(3); rx_strobe = 1'b0; wait_clk(3);
      end
      chk("tab avail after pop", rx_available, 0);
      clear_err();
      chk("tab frame_err cleared", rx_frame_err, 0);
    end

    // empty-FIFO pop is ignored
    rx_strobe = 1'b1; wait_clk(3); rx_strobe = 1'b0; wait_clk(3);
    chk("pop on empty", rx_available, 0);

    // 2-tick glitch rejected
    rx_drv = 1'b0; wait_clk(2 * TICK_DIV); rx_drv = 1'b1;
    wait_clk(12 * BIT);
    chk("glitch avail", rx_available, 0);
    chk("glitch frame_err", rx_frame_err, 0);
    chk("glitch overrun", rx_overrun, 0);

    // 17 frames without popping
    for (int i = 0; i < 17; i++) begin
      r = 8'($urandom_range(0, 255));
      send_frame(r, 1'b1);
      rx_model(r, 1'b1);
    end
    wait_clk(2 * BIT);
    chk("ovr overrun", rx_overrun, exp_ovr);
    chk("ovr frame_err", rx_frame_err, 0);
    while (rx_exp.size() > 0) pop_rx("ovr data");
    chk("ovr drained", rx_available, 0);
    clear_err();
    chk("ovr cleared", rx_overrun, 0);

    // randomized traffic on both paths
    for (int it = 0; it < 8; it++) begin
      b = 8'($urandom_range(0, 255));
      push_tx(b, 1);
      r = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      send_frame(r, st);
      rx_model(r, st);
      wait_clk(2 * BIT);
      chk("rand frame_err", rx_frame_err, exp_ferr);
      chk("rand avail", rx_available, rx_exp.size() != 0);
      while (rx_exp.size() > 0) pop_rx("rand rx data");
      clear_err();
    end
    check_tx("rand tx");

    // loopback 0x00..0x0F
    loopback = 1'b1;
    wait_clk(BIT);
    for (int i = 0; i < 16; i++) begin
      push_tx(8'(i), 1);
      rx_model(8'(i), 1'b1);
    end
    check_tx("loop tx");
    wait_clk(2 * BIT);
    chk("loop overrun", rx_overrun, 0);
    while (rx_exp.size() > 0) pop_rx("loop rx data");
    loopback = 1'b0;
    wait_clk(2 * BIT);

    // reset in the middle of frames on both paths
    send_frame(8'h5A, 1'b1); rx_model(8'h5A, 1'b1);
    send_frame(8'h00, 1'b0); rx_model(8'h00, 1'b0);
    wait_clk(2 * BIT);
    chk("pre-reset avail", rx_available, 1);
    chk("pre-reset frame_err", rx_frame_err, 1);
    push_tx(8'h00, 0);
    rx_drv = 1'b0; wait_clk(BIT); rx_drv = 1'b1;
    wait_clk(3 * BIT);
    chk("pre-reset serial_out low", serial_out, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset serial_out", serial_out, 1);
    chk("async reset tx_full", tx_full, 0);
    chk("async reset rx_available", rx_available, 0);
    chk("async reset rx_frame_err", rx_frame_err, 0);
    chk("async reset rx_overrun", rx_overrun, 0);
    wait_clk(3);
    reset_n = 1'b1;
    tx_exp.delete(); tx_seen.delete(); rx_exp.delete();
    exp_ferr = 1'b0; exp_ovr = 1'b0;
    wait_clk(8 * BIT);
    chk("post-reset no rx byte", rx_available, 0);
    chk("post-reset no frame_err", rx_frame_err, 0);
    chk("post-reset no tx frame", tx_seen.size(), 0);
    push_tx(8'h96, 1);
    send_frame(8'h69, 1'b1); rx_model(8'h69, 1'b1);
    check_tx("post-reset tx");
    wait_clk(2 * BIT);
    pop_rx("post-reset rx data");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
